// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned memory initiator with sign/zero extension and sub-word RMW.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
    parameter int N     = 32,
    parameter int ADR_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             isStore,
    input  logic [1:0]       size,
    input  logic             unsignedLd,
    input  logic [ADR_W-1:0] adr,
    input  logic [N-1:0]     storeData,
    output logic             ready,
    output logic             done,
    output logic [N-1:0]     loadData,
    output logic             err,
    output logic [31:0]      memAdr,
    output logic [N-1:0]     writeData,
    output logic             memWrite,
    input  logic [N-1:0]     readData
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    typedef struct packed {
        logic             isStore;
        logic [1:0]       size;
        logic             unsignedLd;
        logic [ADR_W-1:0] adr;
        logic [N-1:0]     data;
    } lsuReq_t;

    lsuReq_t    reqReg;
    logic [1:0] state;
    logic       misaligned;

    function automatic logic [N-1:0] extractLoad(input logic [N-1:0] w, input logic [1:0] sz,
                                                 input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   return {{(N-8){b[7] & ~uns}}, b};
            2'b01:   return {{(N-16){h[15] & ~uns}}, h};
            default: return w;
        endcase
    endfunction

    // Only the addressed lane is replaced; the rest of the word comes from the RD capture.
    function automatic logic [N-1:0] mergeStore(input logic [N-1:0] old, input logic [1:0] sz,
                                                input logic [1:0] lo, input logic [N-1:0] d);
        logic [N-1:0] m;
        m = old;
        case (sz)
            2'b00:   m[{lo, 3'b000} +: 8]     = d[7:0];
            2'b01:   m[{lo[1], 4'b0000} +: 16] = d[15:0];
            default: m = d;
        endcase
        return m;
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    logic misReg;
    assign misaligned = (size == 2'b01 && adr[0]) || (size[1] && adr[1:0] != 2'b00);
    assign err        = (state == RESP) && misReg;
`else
    assign misaligned = 1'b0;
    assign err        = 1'b0;
`endif

    assign ready    = (state == IDLE);
    assign done     = (state == RESP);
    assign memWrite = (state == WR);
    assign memAdr   = {reqReg.adr[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            reqReg    <= '0;
            writeData <= '0;
            loadData  <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            misReg    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req) begin
                    reqReg.isStore    <= isStore;
                    reqReg.size       <= size;
                    reqReg.unsignedLd <= unsignedLd;
                    reqReg.adr        <= adr;
                    reqReg.data       <= storeData;
`ifdef LSU_MISALIGN_CHECK_EN
                    misReg            <= misaligned;
`endif
                    if (isStore && size[1])
                        writeData <= storeData;
                    if (misaligned)
                        state <= RESP;
                    else if (isStore && size[1])
                        state <= WR;
                    else
                        state <= RD;
                end
                RD: begin
                    if (reqReg.isStore) begin
                        writeData <= mergeStore(readData, reqReg.size, reqReg.adr[1:0], reqReg.data);
                        state     <= WR;
                    end else begin
                        loadData <= extractLoad(readData, reqReg.size, reqReg.adr[1:0],
                                                reqReg.unsignedLd);
                        state    <= RESP;
                    end
                end
                WR:   state <= RESP;
                default: begin
                    state <= IDLE;
`ifdef LSU_MISALIGN_CHECK_EN
                    misReg <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a small word-addressed memory model.
module tb_load_store_unit;

    logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0, isStore = 1'b0, unsignedLd = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] adr = '0, storeData = '0;
    logic        ready, done, err, memWrite;
    logic [31:0] loadData, memAdr, writeData, readData;

    logic [31:0] mem [0:1023];
    int vecs = 0, errs = 0;

    load_store_unit #(.N(32), .ADR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .isStore(isStore), .size(size),
        .unsignedLd(unsignedLd), .adr(adr), .storeData(storeData), .ready(ready),
        .done(done), .loadData(loadData), .err(err), .memAdr(memAdr),
        .writeData(writeData), .memWrite(memWrite), .readData(readData)
    );

    always #5 clk = ~clk;

    assign readData = mem[memAdr[11:2]];
    always @(posedge clk) if (memWrite) mem[memAdr[11:2]] <= writeData;

    // Issue one request from IDLE and observe it to completion, then step back to IDLE.
    task automatic doReq(input logic st, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output int wCnt, output int wCyc,
                         output logic [31:0] wData, output logic [31:0] ld, output logic e);
        isStore = st; size = sz; unsignedLd = u; adr = a; storeData = d; req = 1'b1;
        lat = -1; wCnt = 0; wCyc = -1; wData = '0; ld = '0; e = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            req = 1'b0;
            if (memWrite) begin wCnt++; wCyc = c; wData = writeData; end
            if (done) begin lat = c; ld = loadData; e = err; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        vecs++;
        if ({ready, done, err, memWrite} !== 4'b1000) begin
            errs++; $display("FAIL reset_ctl got %b want 1000", {ready, done, err, memWrite});
        end
        vecs++;
        if (loadData !== 32'h0 || memAdr !== 32'h0 || writeData !== 32'h0) begin
            errs++; $display("FAIL reset_data got %h/%h/%h want 0/0/0", loadData, memAdr, writeData);
        end
        #9 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        logic [31:0] tA [0:6] = '{32'h1000, 32'h1001, 32'h1003, 32'h1002, 32'h1000, 32'h1002, 32'h1000};
        logic [1:0]  tS [0:6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        logic        tU [0:6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] tE [0:6] = '{32'h8899AABB, 32'hFFFFFFAA, 32'h00000088, 32'hFFFF8899,
                                  32'h0000AABB, 32'h00008899, 32'hFFFFFFBB};
        int lat, wCnt, wCyc;
        logic [31:0] wData, ld;
        logic e;
        for (int i = 0; i < 7; i++) begin
            doReq(1'b0, tS[i], tU[i], tA[i], 32'h0, lat, wCnt, wCyc, wData, ld, e);
            vecs++;
            if (ld !== tE[i]) begin errs++; $display("FAIL load%0d_data got %h want %h", i, ld, tE[i]); end
            vecs++;
            if (lat !== 2 || wCnt !== 0 || e !== 1'b0) begin
                errs++; $display("FAIL load%0d_timing got lat=%0d wr=%0d err=%b want 2/0/0", i, lat, wCnt, e);
            end
        end
    endtask

    task automatic test_stores();
        int lat, wCnt, wCyc;
        logic [31:0] wData, ld;
        logic e;
        doReq(1'b1, 2'b00, 1'b0, 32'h1002, 32'h12345677, lat, wCnt, wCyc, wData, ld, e);
        vecs++;
        if (lat !== 3 || wCnt !== 1 || wCyc !== 2 || wData !== 32'h8877AABB) begin
            errs++; $display("FAIL sb got lat=%0d wr=%0d wcyc=%0d wd=%h want 3/1/2/8877aabb", lat, wCnt, wCyc, wData);
        end
        doReq(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, wCnt, wCyc, wData, ld, e);
        vecs++;
        if (ld !== 32'h8877AABB) begin errs++; $display("FAIL sb_readback got %h want 8877aabb", ld); end
        doReq(1'b1, 2'b10, 1'b0, 32'h1004, 32'hDEADBEEF, lat, wCnt, wCyc, wData, ld, e);
        vecs++;
        if (lat !== 2 || wCnt !== 1 || wCyc !== 1 || wData !== 32'hDEADBEEF) begin
            errs++; $display("FAIL sw got lat=%0d wr=%0d wcyc=%0d wd=%h want 2/1/1/deadbeef", lat, wCnt, wCyc, wData);
        end
        vecs++;
        if (loadData !== 32'h8877AABB) begin errs++; $display("FAIL ld_hold got %h want 8877aabb", loadData); end
        doReq(1'b1, 2'b01, 1'b0, 32'h1006, 32'h00001234, lat, wCnt, wCyc, wData, ld, e);
        vecs++;
        if (lat !== 3 || wCnt !== 1 || wData !== 32'h1234BEEF) begin
            errs++; $display("FAIL sh_hi got lat=%0d wr=%0d wd=%h want 3/1/1234beef", lat, wCnt, wData);
        end
        doReq(1'b0, 2'b01, 1'b0, 32'h1004, 32'h0, lat, wCnt, wCyc, wData, ld, e);
        vecs++;
        if (ld !== 32'hFFFFBEEF) begin errs++; $display("FAIL lh_lo got %h want ffffbeef", ld); end
    endtask

    task automatic test_misalign();
        int lat, wCnt, wCyc;
        logic [31:0] wData, ld;
        logic e;
        doReq(1'b1, 2'b10, 1'b0, 32'h1000, 32'h8899AABB, lat, wCnt, wCyc, wData, ld, e);
        doReq(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, wCnt, wCyc, wData, ld, e);
        doReq(1'b1, 2'b01, 1'b0, 32'h1001, 32'h0000CAFE, lat, wCnt, wCyc, wData, ld, e);
`ifdef LSU_MISALIGN_CHECK_EN
        vecs++;
        if (lat !== 1 || e !== 1'b1 || wCnt !== 0) begin
            errs++; $display("FAIL mis_sh got lat=%0d err=%b wr=%0d want 1/1/0", lat, e, wCnt);
        end
`else
        vecs++;
        if (lat !== 3 || e !== 1'b0 || wCnt !== 1 || wData !== 32'h8899CAFE) begin
            errs++; $display("FAIL mis_sh got lat=%0d err=%b wr=%0d wd=%h want 3/0/1/8899cafe", lat, e, wCnt, wData);
        end
`endif
        vecs++;
        if (loadData !== 32'h8899AABB) begin errs++; $display("FAIL mis_ldhold got %h want 8899aabb", loadData); end
        doReq(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, wCnt, wCyc, wData, ld, e);
        vecs++;
`ifdef LSU_MISALIGN_CHECK_EN
        if (ld !== 32'h8899AABB) begin errs++; $display("FAIL mis_mem got %h want 8899aabb", ld); end
`else
        if (ld !== 32'h8899CAFE) begin errs++; $display("FAIL mis_mem got %h want 8899cafe", ld); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat, wCnt, wCyc, wSeen;
        logic [31:0] wData, ld;
        logic e;
        doReq(1'b1, 2'b10, 1'b0, 32'h1000, 32'h8899AABB, lat, wCnt, wCyc, wData, ld, e);
        isStore = 1'b1; size = 2'b00; adr = 32'h1000; storeData = 32'h55; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        vecs++;
        if (ready !== 1'b0) begin errs++; $display("FAIL rmid_busy got ready=%b want 0", ready); end
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({memWrite, done, ready} !== 3'b001 || loadData !== 32'h0) begin
            errs++; $display("FAIL rmid_async got %b ld=%h want 001 ld=0", {memWrite, done, ready}, loadData);
        end
        wSeen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (memWrite) wSeen++;
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        if (memWrite) wSeen++;
        vecs++;
        if (wSeen !== 0) begin errs++; $display("FAIL rmid_nowrite got %0d writes want 0", wSeen); end
        doReq(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, lat, wCnt, wCyc, wData, ld, e);
        vecs++;
        if (ld !== 32'h8899AABB) begin errs++; $display("FAIL rmid_mem got %h want 8899aabb", ld); end
    endtask

    task automatic test_back_to_back(input logic st, input logic [31:0] d, input int period);
        int accepts, dones, last, badGap, overlap;
        accepts = 0; dones = 0; last = -1; badGap = 0; overlap = 0;
        isStore = st; size = 2'b00; unsignedLd = 1'b0; adr = 32'h1001; storeData = d; req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (ready) begin
                if (last >= 0 && c - last != period) badGap++;
                last = c; accepts++;
            end
            if (done) begin dones++; if (ready) overlap++; end
            @(posedge clk); #1;
        end
        req = 1'b0;
        vecs++;
        if (accepts !== 12 / period || badGap !== 0) begin
            errs++; $display("FAIL b2b_p%0d_accept got %0d gaps_bad=%0d want %0d/0", period, accepts, badGap, 12 / period);
        end
        vecs++;
        if (dones !== accepts || overlap !== 0) begin
            errs++; $display("FAIL b2b_p%0d_done got %0d overlap=%0d want %0d/0", period, dones, overlap, accepts);
        end
        for (int c = 0; c < 10; c++) begin
            if (ready) break;
            @(posedge clk); #1;
        end
        vecs++;
        if (ready !== 1'b1) begin errs++; $display("FAIL b2b_p%0d_drain got ready=%b want 1", period, ready); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0] = 32'h8899AABB;
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_reset_mid();
        test_back_to_back(1'b0, 32'h0, 3);
        test_back_to_back(1'b1, 32'hAA, 4);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
